// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared state encoding and default parameter constants for the
//            convolution MAC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DEF_CHANNELS   = 3;
  localparam int DEF_K_SQUARED  = 9;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 255;

  // Transaction phases of the shared multiplier array
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant. Picks the first requester at or
//            above the pointer, wrapping modulo N; one-hot or all-zero output.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  int w_ptr;
  int w_rel;
  int w_best;
  int w_best_ch;

  // Find the requester with the smallest circular distance from the pointer
  always_comb begin
    w_ptr     = int'(i_ptr);
    w_rel     = 0;
    w_best    = N;
    w_best_ch = 0;
    o_grant   = '0;
    for (int c = 0; c < N; c++) begin
      w_rel = (c >= w_ptr) ? (c - w_ptr) : (c + N - w_ptr);
      if (i_req[c] && (w_rel < w_best)) begin
        w_best    = w_rel;
        w_best_ch = c;
      end
    end
    for (int c = 0; c < N; c++) begin
      o_grant[c] = (w_best < N) && (c == w_best_ch);
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_arbiter
// Brief    : Shares one K_SQUARED-lane multiplier array between CHANNELS
//            requesters. Round-robin grant, one issue pulse, bounded wait for
//            the array result (timeout abort), then a held response.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_arbiter
  import conv_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int K_SQUARED  = DEF_K_SQUARED,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                                     axi_clk,
  input  logic                                     axi_reset_n,
  input  logic [CHANNELS-1:0]                      req_valid,
  output logic [CHANNELS-1:0]                      req_ready,
  input  logic [CHANNELS*K_SQUARED*DATA_WIDTH-1:0] req_data,
  input  logic [K_SQUARED*DATA_WIDTH-1:0]          coef_in,
  output logic [K_SQUARED*DATA_WIDTH-1:0]          mac_a,
  output logic [K_SQUARED*DATA_WIDTH-1:0]          mac_b,
  output logic [K_SQUARED-1:0]                     mac_start,
  input  logic                                     mac_done,
  input  logic [DATA_WIDTH-1:0]                    mac_sum,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [DATA_WIDTH-1:0]                    rsp_data,
  output logic [$clog2(CHANNELS)-1:0]              rsp_chan,
  output logic                                     rsp_err,
  output logic                                     busy
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int WIN_W = K_SQUARED * DATA_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_chan;
  logic [WIN_W-1:0]      r_win;
  logic [WIN_W-1:0]      r_coef;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [CHANNELS-1:0]   w_grant;
  logic [PTR_W-1:0]      w_gidx;
  logic [WIN_W-1:0]      w_win;
  logic                  w_accept;
  logic                  w_timeout;

  rr_arbiter #(
    .N     (CHANNELS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Translate the one-hot grant into a channel index and its pixel window
  always_comb begin
    w_gidx = '0;
    w_win  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_grant[c]) begin
        w_gidx = PTR_W'(c);
        w_win  = req_data[c*WIN_W +: WIN_W];
      end
    end
  end

  // Next-state and output decode; reset gates req_ready so it drops at once
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    mac_start = '0;
    mac_a     = '0;
    mac_b     = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_chan  = '0;
    rsp_err   = 1'b0;
    busy      = (r_state != ST_IDLE);
    w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = axi_reset_n ? w_grant : '0;
        w_accept  = |req_ready;
        if (w_accept) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mac_start = '1;
        mac_a     = r_win;
        mac_b     = r_coef;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        mac_a = r_win;
        mac_b = r_coef;
        if (mac_done || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_rsp_data;
        rsp_chan  = r_chan;
        rsp_err   = r_rsp_err;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, operand latch, wait counter and result capture
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_chan     <= '0;
      r_win      <= '0;
      r_coef     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_win  <= w_win;
        r_coef <= coef_in;
        r_chan <= w_gidx;
        r_ptr  <= (w_gidx == PTR_W'(CHANNELS - 1)) ? '0 : w_gidx + PTR_W'(1);
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        // A result arriving on the final wait cycle beats the abort
        if (mac_done) begin
          r_rsp_data <= mac_sum;
          r_rsp_err  <= 1'b0;
          r_cnt      <= '0;
        end else if (w_timeout) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_mac_arbiter.md
CONV_MAC_ARBITER -- requirements
Module: conv_mac_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of requesting channels.
REQ-002 SHALL have parameter K_SQUARED, default 9: multiplier lanes in the shared array.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: operand and result width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-005 axi_clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 axi_reset_n  in  1  reset, asynchronous and active-low.
REQ-007 req_valid  in  CHANNELS  per-channel request valid.
REQ-008 req_ready  out  CHANNELS  per-channel accept; at most one bit high.
REQ-009 req_data  in  CHANNELS*K_SQUARED*DATA_WIDTH  flat window pixels; channel c at c*K_SQUARED*DATA_WIDTH.
REQ-010 coef_in  in  K_SQUARED*DATA_WIDTH  shared filter coefficients.
REQ-011 mac_a  out  K_SQUARED*DATA_WIDTH  multiplier operands (pixels).
REQ-012 mac_b  out  K_SQUARED*DATA_WIDTH  multiplicand operands (coefficients).
REQ-013 mac_start  out  K_SQUARED  per-lane start pulse.
REQ-014 mac_done  in  1  array result valid.
REQ-015 mac_sum  in  DATA_WIDTH  array result.
REQ-016 rsp_valid  out  1;  rsp_ready  in  1  result handshake.
REQ-017 rsp_data  out  DATA_WIDTH;  rsp_chan  out  $clog2(CHANNELS)  result and originating channel.
REQ-018 rsp_err  out  1  result aborted by timeout (rsp_data = 0).
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-021 IDLE: req_ready SHALL be one-hot on the first channel with req_valid high, searching from rr_ptr upward modulo CHANNELS; all zero if none valid.
REQ-022 On req_valid&req_ready of channel g: latch that channel's window and coef_in, latch g, set rr_ptr = (g+1) mod CHANNELS, go to ISSUE.
REQ-023 ISSUE: mac_start SHALL be all-ones for exactly one cycle (the cycle after acceptance); then go to WAIT.
REQ-024 mac_a/mac_b SHALL present the latched operands in ISSUE and WAIT, and zero otherwise.
REQ-025 WAIT: on mac_done capture mac_sum into rsp_data, rsp_err=0, go to RESP; mac_done in any other state SHALL be ignored.
REQ-026 WAIT: a cycle counter SHALL increment each cycle; when it reaches TIMEOUT without mac_done: rsp_data=0, rsp_err=1, go to RESP.
REQ-027 RESP: rsp_valid SHALL be high and rsp_data/rsp_chan/rsp_err stable until rsp_ready; on handshake go to IDLE.
REQ-028 No request SHALL be accepted in the RESP->IDLE transition cycle; minimum issue-to-issue spacing is 4 cycles (one bubble after response).
REQ-029 req_valid dropped before acceptance SHALL cancel that request without side effects.
REQ-030 mac_done and timeout in the same cycle: mac_done SHALL win (rsp_err=0).
REQ-031 rr_ptr SHALL wrap from CHANNELS-1 to 0; grant is starvation-free (each valid channel served within CHANNELS grants).

Reset
REQ-032 Reset assertion SHALL immediately force IDLE, rr_ptr=0, counter=0, and all outputs to 0, including mid-transaction; in-flight results are discarded.
REQ-033 First grant after reset release SHALL occur no earlier than the first rising edge with axi_reset_n high.

Structure
REQ-034 State encoding and default parameter constants SHALL live in a shared package conv_pkg.
REQ-035 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector, pointer; output one-hot grant).

Verification
REQ-036 Single request ch1, mac_done 5 cycles after mac_start, mac_sum=0x1234 -> rsp_valid with rsp_chan=1, rsp_data=0x1234, rsp_err=0.
REQ-037 All three channels valid continuously, rr_ptr=0 -> grant order 0,1,2,0,1,2.
REQ-038 mac_done never asserted -> after 255 WAIT cycles rsp_err=1, rsp_data=0.
REQ-039 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable; no new req_ready during that time.
REQ-040 axi_reset_n low during WAIT -> busy, mac_start, rsp_valid, req_ready all 0 asynchronously; next grant goes to channel 0.
REQ-041 mac_done coincident with timeout cycle, mac_sum=7 -> rsp_data=7, rsp_err=0.
